// File: rtl/result_display_ctrl_pkg.sv
// Shared types and constants for result_display_ctrl and its dwell timer.
package rdc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StClear,
      StRun,
      StShow
   } state_e;

   localparam logic [1:0]  SLOT_LO       = 2'd0;
   localparam logic [1:0]  SLOT_HI       = 2'd1;
   localparam logic [1:0]  SLOT_BLANK    = 2'd2;
   localparam logic [7:0]  BLANK_BYTE    = 8'h00;
   localparam logic [15:0] TIMEOUT_VALUE = 16'hDEAD;

   // Byte shown on the display pins for a given slot.
   function automatic logic [7:0] slot_byte(input logic [1:0] sel, input logic [15:0] value);
      logic [7:0] b;
      case (sel)
         SLOT_LO: b = value[7:0];
         SLOT_HI: b = value[15:8];
         default: b = BLANK_BYTE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/result_display_ctrl_if.sv
// Processor handshake and display bus of result_display_ctrl.
// The controller binds the slave modport; a driver/bench binds master.
interface result_display_ctrl_if;

   logic        start;
   logic        proc_valid;
   logic [15:0] proc_value;
   logic        proc_rst;
   logic        proc_enable;
   logic [7:0]  disp;
   logic [1:0]  byte_sel;
   logic        busy;
   logic        done;
   logic        error;

   modport master (
      output start, proc_valid, proc_value,
      input  proc_rst, proc_enable, disp, byte_sel, busy, done, error
   );

   modport slave (
      input  start, proc_valid, proc_value,
      output proc_rst, proc_enable, disp, byte_sel, busy, done, error
   );

endinterface

// File: rtl/result_display_ctrl_dwell_timer.sv
// Free-running dwell counter: counts 0..CYCLES-1 and pulses o_wrap on the
// terminal-count cycle, wrapping to 0 on the following edge.
module dwell_timer #(
   parameter int unsigned CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_wrap
);

   localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CNT_W-1:0] r_count;
   logic             w_wrap;

   assign w_wrap = (r_count == CNT_W'(CYCLES - 1));
   assign o_wrap = w_wrap;

   // Count up, wrapping at terminal count so the counter never overflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (w_wrap) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/result_display_ctrl.sv
// Runs the processor once per start, captures its 16-bit result and cycles
// it over an 8-bit display: low byte, high byte, blank, each held for
// DWELL_CYCLES clocks.
// Optional feature macro: RUN_TIMEOUT_EN (RUN aborts after TIMEOUT_CYCLES,
// result forced to TIMEOUT_VALUE and sticky error raised).
module result_display_ctrl
   import rdc_pkg::*;
#(
   parameter int unsigned DWELL_CYCLES   = 8_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 16_777_215
) (
   input logic                  clk,
   input logic                  rst_n,
   result_display_ctrl_if.slave bus
);

   state_e      r_state, w_state_d;
   logic [15:0] r_result, w_result_d;
   logic [1:0]  r_byte_sel, w_byte_sel_d;
   logic [7:0]  r_disp;
   logic        r_proc_rst, r_proc_en, r_busy, r_done;
   logic        w_wrap;
   logic        w_timeout;
   logic        w_start_run;

   dwell_timer #(
      .CYCLES(DWELL_CYCLES)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .o_wrap(w_wrap)
   );

   assign w_start_run = ((r_state == StIdle) || (r_state == StShow)) && bus.start;

`ifdef RUN_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] r_run_cnt;
   logic            r_error, w_error_d;

   // Cycles spent in the current RUN; idle at zero outside RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run_cnt <= '0;
      end else if (r_state == StRun) begin
         r_run_cnt <= r_run_cnt + TO_W'(1);
      end else begin
         r_run_cnt <= '0;
      end
   end

   assign w_timeout = (r_state == StRun) && (r_run_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Sticky error: set on timeout (a same-edge capture wins), cleared entering CLEAR.
   always_comb begin
      w_error_d = r_error;
      if (w_start_run) begin
         w_error_d = 1'b0;
      end else if (w_timeout && !bus.proc_valid) begin
         w_error_d = 1'b1;
      end
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_error <= 1'b0;
      end else begin
         r_error <= w_error_d;
      end
   end

   assign bus.error = r_error;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
   assign w_timeout        = 1'b0;
   assign bus.error        = 1'b0;
`endif

   // Next state and result capture.
   always_comb begin
      w_state_d  = r_state;
      w_result_d = r_result;
      unique case (r_state)
         StIdle, StShow: begin
            if (w_start_run) begin
               w_state_d = StClear;
            end
         end
         StClear: begin
            w_state_d = StRun;
         end
         StRun: begin
            if (bus.proc_valid) begin
               w_result_d = bus.proc_value;
               w_state_d  = StShow;
            end else if (w_timeout) begin
               w_result_d = TIMEOUT_VALUE;
               w_state_d  = StShow;
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // Slot advances only on dwell wrap; captures never restart it.
   always_comb begin
      w_byte_sel_d = r_byte_sel;
      if (w_wrap) begin
         w_byte_sel_d = (r_byte_sel == SLOT_BLANK) ? SLOT_LO : r_byte_sel + 2'd1;
      end
   end

   // State, result and registered outputs; outputs are decoded from the
   // next state so they line up with the registered state each cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_result   <= '0;
         r_byte_sel <= SLOT_LO;
         r_disp     <= BLANK_BYTE;
         r_proc_rst <= 1'b1;
         r_proc_en  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_result   <= w_result_d;
         r_byte_sel <= w_byte_sel_d;
         r_disp     <= slot_byte(w_byte_sel_d, w_result_d);
         r_proc_rst <= (w_state_d == StClear);
         r_proc_en  <= (w_state_d == StRun);
         r_busy     <= (w_state_d == StClear) || (w_state_d == StRun);
         r_done     <= (r_state == StRun) && (w_state_d == StShow);
      end
   end

   assign bus.proc_rst    = r_proc_rst;
   assign bus.proc_enable = r_proc_en;
   assign bus.disp        = r_disp;
   assign bus.byte_sel    = r_byte_sel;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Randomized self-checking bench for result_display_ctrl with a
// cycle-level behavioural reference model (DWELL_CYCLES=4, TIMEOUT_CYCLES=20).
module tb_result_display_ctrl;

   localparam int unsigned DWELL   = 4;
   localparam int unsigned TIMEOUT = 20;
`ifdef RUN_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;

   result_display_ctrl_if bus ();

   result_display_ctrl #(
      .DWELL_CYCLES  (DWELL),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: what the controller is doing, not how it encodes it.
   bit          m_rst_hold;  // proc_rst still held from reset
   bit          m_clearing;  // processor being reset this cycle
   bit          m_running;   // processor enabled, waiting for a result
   bit          m_done;
   bit          m_error;
   int          m_run_len;   // cycles already spent running
   int          m_tick;      // edges since reset release
   logic [15:0] m_result;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_rst_hold = 1'b1;
      m_clearing = 1'b0;
      m_running  = 1'b0;
      m_done     = 1'b0;
      m_error    = 1'b0;
      m_run_len  = 0;
      m_tick     = 0;
      m_result   = 16'h0000;
   endtask

   // Advance the model across one rising edge given the inputs sampled there.
   task automatic model_edge(input logic s, input logic v, input logic [15:0] val);
      m_rst_hold = 1'b0;
      m_done     = 1'b0;
      if (m_clearing) begin
         m_clearing = 1'b0;
         m_running  = 1'b1;
         m_run_len  = 0;
      end else if (m_running) begin
         m_run_len++;
         if (v) begin
            m_result  = val;
            m_running = 1'b0;
            m_done    = 1'b1;
         end else if (TO_EN && m_run_len == TIMEOUT) begin
            m_result  = 16'hDEAD;
            m_error   = 1'b1;
            m_running = 1'b0;
            m_done    = 1'b1;
         end
      end else if (s) begin
         m_clearing = 1'b1;
         m_error    = 1'b0;
      end
      m_tick++;
   endtask

   function automatic logic [7:0] exp_disp(input int sel, input logic [15:0] r);
      if (sel == 0) return r[7:0];
      if (sel == 1) return r[15:8];
      return 8'h00;
   endfunction

   task automatic compare_all(input string ph);
      int sel;
      sel = (m_tick / DWELL) % 3;
      check_eq({ph, ".proc_rst"},    32'(bus.proc_rst),    32'(m_rst_hold | m_clearing));
      check_eq({ph, ".proc_enable"}, 32'(bus.proc_enable), 32'(m_running));
      check_eq({ph, ".busy"},        32'(bus.busy),        32'(m_clearing | m_running));
      check_eq({ph, ".done"},        32'(bus.done),        32'(m_done));
      check_eq({ph, ".error"},       32'(bus.error),       32'(m_error));
      check_eq({ph, ".byte_sel"},    32'(bus.byte_sel),    32'(sel));
      check_eq({ph, ".disp"},        32'(bus.disp),        32'(exp_disp(sel, m_result)));
   endtask

   // Drive inputs for one cycle, take the edge, then compare off-edge.
   task automatic step(input string ph, input logic s, input logic v, input logic [15:0] val);
      bus.start      = s;
      bus.proc_valid = v;
      bus.proc_value = val;
      @(posedge clk);
      model_edge(s, v, val);
      #1;
      compare_all(ph);
   endtask

   task automatic idle(input string ph, input int n);
      for (int i = 0; i < n; i++) begin
         step(ph, 1'b0, 1'b0, 16'(($urandom)));
      end
   endtask

   // Asynchronous reset: outputs must change before any clock edge.
   task automatic apply_reset(input string ph);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all(ph);
      @(posedge clk);
      @(posedge clk);
      #3;
      bus.start      = 1'b0;
      bus.proc_valid = 1'b0;
      rst_n          = 1'b1;
   endtask

   initial begin
      rst_n          = 1'b1;
      bus.start      = 1'b0;
      bus.proc_valid = 1'b0;
      bus.proc_value = 16'h0000;
      #3;
      apply_reset("por");

      // First edge after release drops proc_rst; then a start pulse.
      idle("post_rst", 2);
      step("start", 1'b1, 1'b0, 16'h0);
      check_eq("clear.proc_rst", 32'(bus.proc_rst), 32'd1);
      step("clear_exit", 1'b0, 1'b0, 16'h0);
      check_eq("run.proc_enable", 32'(bus.proc_enable), 32'd1);
      check_eq("run.busy", 32'(bus.busy), 32'd1);
      idle("run_wait", 2);
      step("cap_a55a", 1'b0, 1'b1, 16'hA55A);
      check_eq("a55a.done", 32'(bus.done), 32'd1);
      idle("show_a55a", 14);

      // Ignored inputs: proc_valid in SHOW, start in RUN.
      step("pv_show", 1'b0, 1'b1, 16'h1234);
      idle("show2", 2);
      step("start2", 1'b1, 1'b0, 16'h0);
      idle("clr2", 1);
      step("start_in_run", 1'b1, 1'b0, 16'h0);
      idle("run2", 1);
      // Align the capture so it lands while byte_sel is 1 and not wrapping.
      while (!(((m_tick / DWELL) % 3) == 1 && (m_tick % DWELL) < DWELL - 2)) begin
         idle("align", 1);
      end
      step("cap_0102", 1'b0, 1'b1, 16'h0102);
      check_eq("0102.disp_hi", 32'(bus.disp), 32'h01);
      idle("show_0102", 6);

      // Reset in the middle of a run, then a normal run.
      step("start3", 1'b1, 1'b0, 16'h0);
      idle("run3", 3);
      apply_reset("mid_run_rst");
      idle("post_rst2", 1);
      step("start4", 1'b1, 1'b0, 16'h0);
      idle("run4", 2);
      step("cap4", 1'b0, 1'b1, 16'hBEEF);
      idle("show4", 4);

      // Long run with no result: timeout when enabled, else keeps waiting.
      step("start5", 1'b1, 1'b0, 16'h0);
      idle("long_run", TIMEOUT + 5);
      step("late_pv", 1'b0, 1'b1, 16'h4321);
      idle("show5", 3);
      step("start6", 1'b1, 1'b0, 16'h0);
      idle("run6", 2);
      step("cap6", 1'b0, 1'b1, 16'h7E81);
      idle("show6", 2);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
              16'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/result_display_ctrl.md
RESULT_DISPLAY_CTRL -- requirements
Module: result_display_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 8_000_000: clock cycles each display slot is held; legal range 2..2^24.
REQ-002 Parameter TIMEOUT_CYCLES, default 16_777_215: maximum RUN length in cycles; used only with RUN_TIMEOUT_EN.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  level sampled each cycle; a high sample in IDLE or SHOW begins a new run.
REQ-006 proc_valid  in  1  processor result-valid strobe.
REQ-007 proc_value  in  16  processor result; sampled only when proc_valid is high in RUN.
REQ-008 proc_rst  out  1  synchronous reset to the processor, active-high.
REQ-009 proc_enable  out  1  processor run enable.
REQ-010 disp  out  8  byte presented to the 8 display pins.
REQ-011 byte_sel  out  2  current display slot: 0 = result[7:0], 1 = result[15:8], 2 = blank.
REQ-012 busy  out  1  high in CLEAR and RUN.
REQ-013 done  out  1  one-cycle pulse on entry to SHOW.
REQ-014 error  out  1  sticky timeout flag; cleared on entry to CLEAR.

Function
REQ-015 FSM states: IDLE, CLEAR, RUN, SHOW; registered outputs, decoded from the registered state.
REQ-016 IDLE/SHOW with start=1 -> CLEAR on the next edge; otherwise remain.
REQ-017 CLEAR lasts exactly 1 cycle, with proc_rst=1 and proc_enable=0; CLEAR -> RUN unconditionally.
REQ-018 RUN: proc_rst=0, proc_enable=1; a cycle with proc_valid=1 captures proc_value into result at that edge and moves to SHOW.
REQ-019 Latency: done is high in the cycle after the capturing edge; result is stable from that cycle on.
REQ-020 SHOW: proc_enable=0, proc_rst=0; result is held until the next capture.
REQ-021 proc_valid outside RUN is ignored; start during CLEAR or RUN is ignored.
REQ-022 Dwell counter counts 0..DWELL_CYCLES-1 in every state; at terminal count it wraps to 0 and byte_sel advances 0->1->2->0.
REQ-023 disp is a registered function of byte_sel and result per REQ-011; slot 2 drives 8'h00.
REQ-024 A new capture does not reset the dwell counter or byte_sel; the new bytes appear from the next edge.
REQ-025 Dwell counter width is clog2(DWELL_CYCLES); no overflow beyond terminal count.

Reset
REQ-026 rst_n low immediately forces: state=IDLE, proc_rst=1, proc_enable=0, result=0, disp=0, byte_sel=0, dwell=0, busy=0, done=0, error=0.
REQ-027 proc_rst deasserts on the first clk edge after rst_n rises, including when reset is asserted mid-RUN.

Configuration
REQ-028 Macro RUN_TIMEOUT_EN defined: a RUN cycle counter that reaches TIMEOUT_CYCLES with no proc_valid forces result=16'hDEAD, error=1, SHOW, done pulse; proc_valid on that same edge takes priority (normal capture, error=0).
REQ-029 Macro RUN_TIMEOUT_EN undefined: no timeout counter exists, RUN waits indefinitely, and error is tied to 0.

Structure
REQ-030 Shared package rdc_pkg holds the state enum, slot encodings (SLOT_LO/SLOT_HI/SLOT_BLANK), BLANK_BYTE=8'h00, and TIMEOUT_VALUE=16'hDEAD.
REQ-031 One sub-module, dwell_timer (parameterised terminal count, wrap pulse output), holds the dwell counter; the FSM and display mux stay in result_display_ctrl.

Verification (DWELL_CYCLES=4, TIMEOUT_CYCLES=20)
REQ-032 Reset release, start=1 for 1 cycle -> proc_rst high for exactly 1 cycle, then proc_enable=1 and busy=1.
REQ-033 In RUN, proc_valid=1 with proc_value=16'hA55A -> done pulses once; disp cycles 8'h5A, 8'hA5, 8'h00, each held 4 cycles.
REQ-034 proc_valid pulses in IDLE and SHOW, and start pulses in RUN -> no state or result change.
REQ-035 rst_n asserted mid-RUN -> all outputs take their reset values asynchronously; the next start completes a normal run.
REQ-036 RUN_TIMEOUT_EN defined, no proc_valid for 20 cycles -> result=16'hDEAD, error=1, done pulse; the next start clears error.
REQ-037 Second run capturing 16'h0102 while byte_sel=1 -> the next cycle shows disp=8'h01 with no dwell restart.
